// File: rtl/din_debounce_pkg.sv
// Shared constants for the din_debounce input-conditioning stage:
// FSM state encodings and default qualification parameters.
package din_debounce_pkg;

    localparam logic [1:0] ST_LO   = 2'd0;
    localparam logic [1:0] WAIT_HI = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;
    localparam logic [1:0] WAIT_LO = 2'd3;

    localparam int DEFAULT_STABLE_CYCLES = 4;
    localparam int DEFAULT_CNT_W         = 8;

endpackage

// File: rtl/din_debounce_sync_2ff.sv
// Reusable two-flop synchroniser for a single asynchronous bit,
// cleared asynchronously by an active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/din_debounce.sv
// Debouncer: synchronises a raw bit, accepts a level change only after it has
// held for STABLE_CYCLES samples, and emits registered one-cycle rise/fall pulses.
module din_debounce
    import din_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic din_raw,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             din_s;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             dout_q,  dout_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;
    logic             busy_q,  busy_d;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din_raw),
        .q   (din_s)
    );

    // The sample that leaves a stable state counts as the first stable sample,
    // so the WAIT states start at cnt=1 and finish when cnt reaches STABLE_CYCLES-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_LO: begin
                if (din_s) begin
                    state_d = WAIT_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_HI: begin
                if (!din_s) begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HI;
                    cnt_d   = '0;
                    dout_d  = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_HI: begin
                if (!din_s) begin
                    state_d = WAIT_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_LO: begin
                if (din_s) begin
                    state_d = ST_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                    dout_d  = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LO;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LO;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_din_debounce.sv
// Scoreboard bench for din_debounce: stimulus queues expected rise/fall pulses,
// a monitor pops them as the DUT pulses; level and busy checks are directed.
module tb_din_debounce;

    logic clk = 1'b0;
    logic rst;
    logic dinRaw;
    logic dout;
    logic rise;
    logic fall;
    logic busy;

    typedef struct {
        bit isRise;
        int cycle;
    } edge_t;

    edge_t expQ[$];
    edge_t gotEv;
    int    cycleCount = 0;
    int    checkCount = 0;
    int    failCount  = 0;

    // busy after each of the 7 edges following a qualifying change
    int busyTable[7] = '{0, 0, 1, 1, 1, 0, 0};

    always #5 clk = ~clk;

    din_debounce #(
        .STABLE_CYCLES (4),
        .CNT_W         (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .din_raw (dinRaw),
        .dout    (dout),
        .rise    (rise),
        .fall    (fall),
        .busy    (busy)
    );

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %b, expected %b (cycle %0d)", name, actual, expected, cycleCount);
        end
    endtask

    // Drives a new raw level on the next negedge; an expected pulse lands 6 edges later.
    task automatic applyStimulus(input logic level, input bit expectEdge);
        @(negedge clk);
        dinRaw = level;
        if (expectEdge)
            expQ.push_back('{isRise: level, cycle: cycleCount + 6});
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: compare every rise/fall pulse against the scoreboard head.
    always @(posedge clk) begin
        #1;
        cycleCount++;
        if (rise || fall) begin
            checkCount++;
            if (rise && fall) begin
                failCount++;
                $display("[TB] FAIL exclusive: rise=%b fall=%b both high (cycle %0d)", rise, fall, cycleCount);
            end else if (expQ.size() == 0) begin
                failCount++;
                $display("[TB] FAIL unexpectedPulse: rise=%b fall=%b, none expected (cycle %0d)", rise, fall, cycleCount);
            end else begin
                gotEv = expQ.pop_front();
                if (gotEv.isRise != rise || gotEv.cycle != cycleCount) begin
                    failCount++;
                    $display("[TB] FAIL pulse: got rise=%b at cycle %0d, expected rise=%b at cycle %0d",
                             rise, cycleCount, gotEv.isRise, gotEv.cycle);
                end
            end
        end
        while (expQ.size() > 0 && expQ[0].cycle < cycleCount) begin
            gotEv = expQ.pop_front();
            checkCount++;
            failCount++;
            $display("[TB] FAIL missedPulse: got nothing by cycle %0d, expected rise=%b at cycle %0d",
                     cycleCount, gotEv.isRise, gotEv.cycle);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        dinRaw = 1'b0;
        #2;
        checkOutput("resetDout", dout, 1'b0);
        checkOutput("resetRise", rise, 1'b0);
        checkOutput("resetFall", fall, 1'b0);
        checkOutput("resetBusy", busy, 1'b0);
        waitCycles(2);
        rst = 1'b0;
        waitCycles(3);

        $display("[TB] glitch reject");
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("glitchBusy", busy, (k < 2) ? 1'b1 : 1'b0);
            checkOutput("glitchDout", dout, 1'b0);
        end
        waitCycles(3);

        $display("[TB] clean rise");
        applyStimulus(1'b1, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checkOutput("riseBusy", busy, busyTable[k-1] != 0);
            checkOutput("riseDout", dout, (k >= 6) ? 1'b1 : 1'b0);
        end
        waitCycles(3);

        $display("[TB] clean fall");
        applyStimulus(1'b0, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checkOutput("fallBusy", busy, busyTable[k-1] != 0);
            checkOutput("fallDout", dout, (k >= 6) ? 1'b0 : 1'b1);
        end
        waitCycles(3);

        $display("[TB] bounce then settle");
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checkOutput("bounceDout", dout, (k >= 6) ? 1'b1 : 1'b0);
        end
        waitCycles(2);

        $display("[TB] async reset while high");
        @(posedge clk);
        #2;
        rst    = 1'b1;
        dinRaw = 1'b0;
        #1;
        checkOutput("asyncDout", dout, 1'b0);
        checkOutput("asyncRise", rise, 1'b0);
        checkOutput("asyncFall", fall, 1'b0);
        checkOutput("asyncBusy", busy, 1'b0);
        waitCycles(2);
        rst = 1'b0;
        waitCycles(4);
        checkOutput("postResetDout", dout, 1'b0);

        $display("[TB] reset mid-qualification");
        applyStimulus(1'b1, 1'b0);
        waitCycles(4);
        checkOutput("midQualBusy", busy, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("midQualRstBusy", busy, 1'b0);
        waitCycles(2);
        rst = 1'b0;
        expQ.push_back('{isRise: 1'b1, cycle: cycleCount + 6});
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checkOutput("releaseBusy", busy, busyTable[k-1] != 0);
            checkOutput("releaseDout", dout, (k >= 6) ? 1'b1 : 1'b0);
        end
        waitCycles(3);

        checkCount++;
        if (expQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL pendingPulses: got %0d outstanding, expected 0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
